hough_vote_gen: RTL and testbench
=================================

Name: hough_vote_gen

Overview:
Upstream driver and downstream consumer around the sin_mult/cos_mult pair in the Hough transform pipeline.
- Accepts edge pixels (x, y) over a valid/ready stream.
- Sweeps theta 0..THETA_STEPS-1 into the external cos_mult (a = x) and sin_mult (a = y) instances.
- Sums and rounds their fixed-point products into rho.
- Emits offset (rho, theta) votes over a back-pressured stream to the accumulator.

Parameters:
COORD_WIDTH, 10, pixel coordinate width (unsigned)
PROD_WIDTH, 18, signed width of each multiplier product (mult instances configured to match)
THETA_WIDTH, 8, theta index width
THETA_STEPS, 180, thetas per pixel (0..179, 1 degree steps)
FRAC_BITS, 7, fractional bits of trig tables (1.0 = 128)
MULT_LATENCY, 2, cycles from mult_theta/mult_x/mult_y to valid product
RHO_OFFSET, 1024, added to signed rho so the output is unsigned
RHO_WIDTH, 12, output rho width
FIFO_DEPTH, 8, vote output FIFO depth (power of 2, >= MULT_LATENCY+2)

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_valid  in  1  pixel valid
s_ready  out  1  pixel ready
s_x  in  COORD_WIDTH  pixel x
s_y  in  COORD_WIDTH  pixel y
s_last  in  1  last edge pixel of frame
mult_x  out  COORD_WIDTH  to cos_mult a (zero-extended by parent)
mult_y  out  COORD_WIDTH  to sin_mult a
mult_theta  out  THETA_WIDTH  to both table theta inputs
cos_prod  in  PROD_WIDTH  signed x*cos from cos_mult
sin_prod  in  PROD_WIDTH  signed y*sin from sin_mult
m_valid  out  1  vote valid
m_ready  in  1  vote ready
m_rho  out  RHO_WIDTH  rho + RHO_OFFSET
m_theta  out  THETA_WIDTH  theta index of vote
m_last  out  1  final vote (theta = THETA_STEPS-1) of the s_last pixel
busy  out  1  sweep active or votes in flight/queued

Behaviour:
- Reset (synchronous, active-high) clears FSM to IDLE, theta counter, valid/tag pipeline, sum stage and FIFO.
  - Outputs while areset high: s_ready=0, mult_x=mult_y=mult_theta=0, m_valid=0, m_rho=0, m_theta=0, m_last=0, busy=0.
  - First cycle after release: s_ready=1.
- FSM IDLE: s_ready=1. On s_valid&&s_ready, register x, y, last; theta=0; go to SWEEP.
- FSM SWEEP: s_ready=0. An issue happens when fifo_count + inflight < FIFO_DEPTH.
  - inflight = number of set valid bits across the MULT_LATENCY tag stages plus the sum stage.
  - A same-cycle pop is not credited.
  - On issue: mult_theta=theta; push tag {valid=1, theta, last_flag = last && theta==THETA_STEPS-1} into the tag pipe; theta++.
  - No issue: push valid=0; mult_* hold their values.
  - Issuing theta THETA_STEPS-1 returns the FSM to IDLE. There is no wrap within a pixel.
- Multipliers never stall. The tag pipe is exactly MULT_LATENCY deep so tag and products align.
- Sum stage (registered, +1 cycle):
  - sum = sext(cos_prod) + sext(sin_prod), PROD_WIDTH+1 bits.
  - rho = (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half up.
  - m_rho = rho + RHO_OFFSET truncated to RHO_WIDTH.
  - Default parameters guarantee range [0, 2479]; no saturation.
- FIFO: first-word-fall-through. m_valid = !empty. Pop on m_valid&&m_ready. Push and pop in the same cycle are both honoured, including when full. Push when full cannot occur because of the credit rule.
- Latency: accept at cycle 0, theta 0 issued cycle 1, product at 1+MULT_LATENCY, m_valid for theta 0 at cycle 2+MULT_LATENCY+1 (cycle 5 default).
- Throughput: with m_ready=1, one vote per cycle. One bubble per pixel (IDLE accept cycle), so 181 cycles per pixel.
- Vote order per pixel is theta ascending and contiguous. Pixels are never interleaved.
- busy = (state==SWEEP) || inflight!=0 || !empty.
- Reset mid-sweep: all in-flight and queued votes are discarded; m_valid=0 the cycle after reset asserts.

Decomposition:
- Package hough_pkg: THETA_STEPS, FRAC_BITS, RHO_OFFSET, COORD/THETA/RHO/PROD widths, vote struct {rho, theta, last}, FSM enum {IDLE, SWEEP}.
- Shared with the trig table generator and the accumulator.
- One sub-module: hough_vote_fifo (synchronous FWFT FIFO, parameterised depth/width, exposes count).

Test Plan:
1. Parent instantiates real cos_mult/sin_mult. x=10, y=0, s_last=1, m_ready=1 -> 180 votes:
   - theta0 rho=1034; theta90 rho=1024; theta179 rho=1014 with m_last=1.
   - First m_valid 5 cycles after accept.
2. x=0, y=100 -> theta90 rho=1124 (sin 0x80); theta30 rho=1074 (sin 0x40); theta0 rho=1024.
3. x=1023, y=1023, theta45 (cos=sin=0x5b) -> sum 186186, rho=1455, m_rho=2479; no overflow.
4. Hold m_ready=0 from 2nd vote for 30 cycles -> exactly FIFO_DEPTH votes queued, issue stalls, mult_theta holds. Release -> all 180 votes delivered, theta contiguous, none lost or duplicated.
5. Two pixels back-to-back, s_last on second -> 360 votes; 1 idle cycle between theta179 and next theta0 issue; m_last asserted once only.
6. Assert areset one cycle while theta=57 issuing -> m_valid=0, busy=0 next cycle; s_ready=1 after release; new pixel starts at theta0 with no stale votes.

Source files
------------

// File: rtl/hough_pkg.sv
// Shared definitions for the Hough transform pipeline: default widths,
// sweep geometry, the vote record and the vote generator sweep states.
package hough_pkg;

    localparam int COORD_W      = 10;
    localparam int PROD_W       = 18;
    localparam int THETA_W      = 8;
    localparam int RHO_W        = 12;
    localparam int THETA_STEPS  = 180;
    localparam int FRAC_BITS    = 7;
    localparam int MULT_LATENCY = 2;
    localparam int RHO_OFFSET   = 1024;
    localparam int FIFO_DEPTH   = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    typedef struct packed {
        logic [RHO_W-1:0]   rho;
        logic [THETA_W-1:0] theta;
        logic               last;
    } vote_t;

    // True when a theta index is the final step of a pixel sweep.
    function automatic logic is_final_theta(input logic [THETA_W-1:0] theta);
        return (theta == THETA_W'(THETA_STEPS - 1));
    endfunction

endpackage

// File: rtl/hough_vote_fifo.sv
// Synchronous first-word-fall-through FIFO for votes. The head word is
// visible on o_data whenever o_empty is low. A push while full is accepted
// when a pop happens in the same cycle.
module hough_vote_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 21
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hough_vote_gen.sv
// Hough vote generator: accepts edge pixels, sweeps theta through the
// external cos/sin multipliers, rounds x*cos + y*sin into an offset rho and
// queues (rho, theta) votes for the accumulator. Issue is credit-limited so
// every vote in flight always has a FIFO slot waiting for it.
module hough_vote_gen
    import hough_pkg::*;
#(
    parameter int COORD_WIDTH   = COORD_W,
    parameter int PROD_WIDTH    = PROD_W,
    parameter int THETA_WIDTH   = THETA_W,
    parameter int THETA_STEPS   = hough_pkg::THETA_STEPS,
    parameter int FRAC_BITS     = hough_pkg::FRAC_BITS,
    parameter int MULT_LATENCY  = hough_pkg::MULT_LATENCY,
    parameter int RHO_OFFSET    = hough_pkg::RHO_OFFSET,
    parameter int RHO_WIDTH     = RHO_W,
    parameter int FIFO_DEPTH    = hough_pkg::FIFO_DEPTH
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [COORD_WIDTH-1:0] s_x,
    input  logic [COORD_WIDTH-1:0] s_y,
    input  logic                   s_last,
    output logic [COORD_WIDTH-1:0] mult_x,
    output logic [COORD_WIDTH-1:0] mult_y,
    output logic [THETA_WIDTH-1:0] mult_theta,
    input  logic [PROD_WIDTH-1:0]  cos_prod,
    input  logic [PROD_WIDTH-1:0]  sin_prod,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [RHO_WIDTH-1:0]   m_rho,
    output logic [THETA_WIDTH-1:0] m_theta,
    output logic                   m_last,
    output logic                   busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int RND_W = PROD_WIDTH + 2;
    localparam logic [THETA_WIDTH-1:0] THETA_LAST = THETA_WIDTH'(THETA_STEPS - 1);
    localparam logic [RND_W-1:0]       HALF_LSB   = RND_W'(1) << (FRAC_BITS - 1);
    localparam logic [RND_W-1:0]       OFFSET_EXT = RND_W'(RHO_OFFSET);
    localparam logic [CNT_W:0]         DEPTH_EXT  = (CNT_W+1)'(FIFO_DEPTH);

    sweep_state_e             r_state;
    sweep_state_e             w_state_next;
    logic [COORD_WIDTH-1:0]   r_x;
    logic [COORD_WIDTH-1:0]   r_y;
    logic                     r_last;
    logic [THETA_WIDTH-1:0]   r_theta;
    logic [COORD_WIDTH-1:0]   r_mult_x;
    logic [COORD_WIDTH-1:0]   r_mult_y;
    logic [THETA_WIDTH-1:0]   r_mult_theta;

    logic                     w_s_ready_fsm;
    logic                     w_sweeping;
    logic                     w_issue;
    logic                     w_accept;

    logic [MULT_LATENCY-1:0]  r_tag_valid;
    logic [MULT_LATENCY-1:0]  r_tag_last;
    logic [THETA_WIDTH-1:0]   r_tag_theta [MULT_LATENCY];

    logic signed [RND_W-1:0]  w_round;
    logic signed [RND_W-1:0]  w_rho_s;
    logic [RHO_WIDTH-1:0]     w_rho;
    logic                     r_sum_valid;
    vote_t                    r_sum_vote;

    logic [CNT_W-1:0]         w_inflight;
    logic [CNT_W-1:0]         w_fifo_count;
    logic [CNT_W:0]           w_committed;
    logic                     w_fifo_empty;
    logic                     w_pop;
    vote_t                    w_head;

    assign w_accept    = s_valid && s_ready;
    assign w_committed = {1'b0, w_fifo_count} + {1'b0, w_inflight};
    assign w_pop       = m_valid && m_ready;

    // Sweep state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: accept a pixel in IDLE, return after issuing the last theta.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_SWEEP;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (w_issue && (r_theta == THETA_LAST)) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SWEEP;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State decode plus credit check; an issue needs a guaranteed FIFO slot.
    always_comb begin
        w_s_ready_fsm = 1'b0;
        w_sweeping    = 1'b0;
        case (r_state)
            ST_IDLE:  w_s_ready_fsm = 1'b1;
            ST_SWEEP: w_sweeping    = 1'b1;
            default: begin
                w_s_ready_fsm = 1'b0;
                w_sweeping    = 1'b0;
            end
        endcase
        if (w_sweeping && (w_committed < DEPTH_EXT)) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    // Votes in flight: set tag bits plus the sum stage.
    always_comb begin
        w_inflight = CNT_W'(r_sum_valid);
        for (int i = 0; i < MULT_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_tag_valid[i]);
        end
    end

    // Pixel capture and theta counter.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_last  <= 1'b0;
            r_theta <= '0;
        end else if (w_accept) begin
            r_x     <= s_x;
            r_y     <= s_y;
            r_last  <= s_last;
            r_theta <= '0;
        end else if (w_issue) begin
            r_theta <= r_theta + THETA_WIDTH'(1);
        end
    end

    // Last issued multiplier operands, presented again while issue stalls.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_mult_x     <= '0;
            r_mult_y     <= '0;
            r_mult_theta <= '0;
        end else if (w_issue) begin
            r_mult_x     <= r_x;
            r_mult_y     <= r_y;
            r_mult_theta <= r_theta;
        end
    end

    // Tag pipe matching the multiplier latency so tags meet their products.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tag_valid <= '0;
            r_tag_last  <= '0;
            for (int i = 0; i < MULT_LATENCY; i++) begin
                r_tag_theta[i] <= '0;
            end
        end else begin
            r_tag_valid[0] <= w_issue;
            r_tag_last[0]  <= w_issue && r_last && (r_theta == THETA_LAST);
            r_tag_theta[0] <= r_theta;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_last[i]  <= r_tag_last[i-1];
                r_tag_theta[i] <= r_tag_theta[i-1];
            end
        end
    end

    // Sum both products, round half up at the binary point, add the offset.
    always_comb begin
        w_round = {{2{cos_prod[PROD_WIDTH-1]}}, cos_prod}
                + {{2{sin_prod[PROD_WIDTH-1]}}, sin_prod}
                + HALF_LSB;
        w_rho_s = w_round >>> FRAC_BITS;
        w_rho   = RHO_WIDTH'(w_rho_s + OFFSET_EXT);
    end

    // Registered sum stage feeding the FIFO.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_sum_valid <= 1'b0;
            r_sum_vote  <= '0;
        end else begin
            r_sum_valid      <= r_tag_valid[MULT_LATENCY-1];
            r_sum_vote.rho   <= w_rho;
            r_sum_vote.theta <= r_tag_theta[MULT_LATENCY-1];
            r_sum_vote.last  <= r_tag_last[MULT_LATENCY-1];
        end
    end

    hough_vote_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(vote_t))
    ) u_fifo (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_push  (r_sum_valid),
        .i_data  (r_sum_vote),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Port drive: everything quiet while reset is held.
    always_comb begin
        if (areset) begin
            s_ready    = 1'b0;
            mult_x     = '0;
            mult_y     = '0;
            mult_theta = '0;
            busy       = 1'b0;
        end else begin
            s_ready    = w_s_ready_fsm;
            mult_x     = w_issue ? r_x     : r_mult_x;
            mult_y     = w_issue ? r_y     : r_mult_y;
            mult_theta = w_issue ? r_theta : r_mult_theta;
            busy       = w_sweeping || (w_inflight != '0) || !w_fifo_empty;
        end
    end

    // Vote stream: head of the FIFO, zeroed when nothing is queued.
    always_comb begin
        if (areset || w_fifo_empty) begin
            m_valid = 1'b0;
            m_rho   = '0;
            m_theta = '0;
            m_last  = 1'b0;
        end else begin
            m_valid = 1'b1;
            m_rho   = w_head.rho;
            m_theta = w_head.theta;
            m_last  = is_final_theta(w_head.theta) && w_head.last;
        end
    end

endmodule

// File: tb/tb_hough_vote_gen.sv
// Bench for hough_vote_gen: models the external cos/sin multipliers,
// scoreboards every vote and checks latency, back-pressure, back-to-back
// pixels and mid-sweep reset.
module tb_hough_vote_gen;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  s_x;
    logic [9:0]  s_y;
    logic        s_last;
    logic [9:0]  mult_x;
    logic [9:0]  mult_y;
    logic [7:0]  mult_theta;
    logic [17:0] cos_prod = 18'd0;
    logic [17:0] sin_prod = 18'd0;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_rho;
    logic [7:0]  m_theta;
    logic        m_last;
    logic        busy;

    hough_vote_gen dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_x        (s_x),
        .s_y        (s_y),
        .s_last     (s_last),
        .mult_x     (mult_x),
        .mult_y     (mult_y),
        .mult_theta (mult_theta),
        .cos_prod   (cos_prod),
        .sin_prod   (sin_prod),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_rho      (m_rho),
        .m_theta    (m_theta),
        .m_last     (m_last),
        .busy       (busy)
    );

    always #5 aclk = ~aclk;

    // Trig tables, round(128 * trig(theta degrees)).
    int cos_tab [256];
    int sin_tab [256];

    // Two-cycle multiplier model standing in for cos_mult / sin_mult.
    logic [17:0] c1 = 18'd0;
    logic [17:0] s1 = 18'd0;
    always @(posedge aclk) begin
        c1       <= 18'(int'(mult_x) * cos_tab[mult_theta]);
        s1       <= 18'(int'(mult_y) * sin_tab[mult_theta]);
        cos_prod <= c1;
        sin_prod <= s1;
    end

    typedef struct {
        int rho;
        int theta;
        bit last;
    } exp_t;

    typedef struct {
        int x;
        int y;
        bit last;
        int theta;
        int exp_rho;
        bit exp_last;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   got_rho  [256];
    int   got_last [256];
    int   vote_cyc [400];
    int   vote_cnt;
    int   last_cnt;
    int   first_valid_cyc;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    function automatic int exp_rho(input int x, input int y, input int th);
        int s;
        s = x * cos_tab[th] + y * sin_tab[th];
        return (((s + 64) >>> 7) + 1024) & 32'hFFF;
    endfunction

    task automatic reset_track();
        vote_cnt = 0;
        last_cnt = 0;
        first_valid_cyc = -1;
        for (int t = 0; t < 256; t++) begin
            got_rho[t]  = -1;
            got_last[t] = -1;
        end
    endtask

    task automatic send_pixel(input int x, input int y, input bit last, output int acc);
        exp_t e;
        s_x = 10'(x);
        s_y = 10'(y);
        s_last = last;
        s_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 500; k++) begin
            @(negedge aclk);
            if (s_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            fail_now("accept_timeout");
        end else begin
            for (int th = 0; th < 180; th++) begin
                e.rho = exp_rho(x, y, th);
                e.theta = th;
                e.last = last && (th == 179);
                exp_q.push_back(e);
            end
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge aclk);
            if (!busy && !m_valid && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now($sformatf("drain_timeout queue=%0d", exp_q.size()));
    endtask

    // Cycle counter, read only away from the rising edge.
    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    // Vote monitor: every handshake is compared with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (!areset && m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (!areset && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("unexpected_vote theta=%0d rho=%0d", m_theta, m_rho));
                end else begin
                    e = exp_q.pop_front();
                    check("vote_theta", int'(m_theta), e.theta);
                    check("vote_rho", int'(m_rho), e.rho);
                    check("vote_last", int'(m_last), int'(e.last));
                end
                got_rho[m_theta]  = int'(m_rho);
                got_last[m_theta] = int'(m_last);
                if (vote_cnt < 400) vote_cyc[vote_cnt] = cyc;
                vote_cnt++;
                if (m_last) last_cnt++;
            end
        end
    end

    initial begin
        vec_t vecs [7];
        int   acc;
        int   acc2;
        bit   found;
        real  rad;

        vecs[0] = '{10, 0, 1'b1, 0, 1034, 1'b0};
        vecs[1] = '{10, 0, 1'b1, 90, 1024, 1'b0};
        vecs[2] = '{10, 0, 1'b1, 179, 1014, 1'b1};
        vecs[3] = '{0, 100, 1'b0, 90, 1124, 1'b0};
        vecs[4] = '{0, 100, 1'b0, 30, 1074, 1'b0};
        vecs[5] = '{0, 100, 1'b0, 0, 1024, 1'b0};
        vecs[6] = '{1023, 1023, 1'b0, 45, 2479, 1'b0};

        for (int t = 0; t < 256; t++) begin
            rad = t * 3.14159265358979 / 180.0;
            cos_tab[t] = $rtoi($floor(128.0 * $cos(rad) + 0.5));
            sin_tab[t] = $rtoi($floor(128.0 * $sin(rad) + 0.5));
        end

        areset = 1'b1;
        s_valid = 1'b0;
        s_x = 10'd0;
        s_y = 10'd0;
        s_last = 1'b0;
        m_ready = 1'b1;
        reset_track();

        // Reset state.
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_mult_theta", int'(mult_theta), 0);
        check("rst_mult_x", int'(mult_x), 0);
        check("rst_m_rho", int'(m_rho), 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_s_ready", int'(s_ready), 1);
        check("post_rst_busy", int'(busy), 0);
        @(posedge aclk);
        #1;

        // Table-driven rho vectors, one full pixel sweep each.
        for (int i = 0; i < 7; i++) begin
            reset_track();
            send_pixel(vecs[i].x, vecs[i].y, vecs[i].last, acc);
            wait_drain(400);
            check($sformatf("vec%0d_rho", i), got_rho[vecs[i].theta], vecs[i].exp_rho);
            check($sformatf("vec%0d_last", i), got_last[vecs[i].theta], int'(vecs[i].exp_last));
            check($sformatf("vec%0d_count", i), vote_cnt, 180);
            if (i == 0) check("first_vote_latency", first_valid_cyc - acc, 5);
            @(posedge aclk);
            #1;
        end

        // Back-pressure: stall after the first vote.
        reset_track();
        send_pixel(37, 200, 1'b0, acc);
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge aclk);
            #1;
            if (vote_cnt >= 1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("first_vote_timeout");
        m_ready = 1'b0;
        repeat (30) @(posedge aclk);
        @(negedge aclk);
        check("stall_mult_theta", int'(mult_theta), 8);
        check("stall_m_theta", int'(m_theta), 1);
        check("stall_m_valid", int'(m_valid), 1);
        check("stall_busy", int'(busy), 1);
        check("stall_votes", vote_cnt, 1);
        repeat (5) @(negedge aclk);
        check("stall_mult_hold", int'(mult_theta), 8);
        @(posedge aclk);
        #1;
        m_ready = 1'b1;
        wait_drain(400);
        check("stall_total_votes", vote_cnt, 180);
        check("stall_last_cnt", last_cnt, 0);
        @(posedge aclk);
        #1;

        // Two pixels back-to-back.
        reset_track();
        send_pixel(5, 7, 1'b0, acc);
        send_pixel(300, 150, 1'b1, acc2);
        wait_drain(800);
        check("b2b_votes", vote_cnt, 360);
        check("b2b_last_cnt", last_cnt, 1);
        check("b2b_accept_gap", acc2 - acc, 181);
        check("b2b_vote_gap", vote_cyc[180] - vote_cyc[179], 2);
        check("b2b_contig", vote_cyc[179] - vote_cyc[0], 179);
        @(posedge aclk);
        #1;

        // Reset while theta 57 is issuing.
        reset_track();
        send_pixel(77, 33, 1'b0, acc);
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge aclk);
            #1;
            if (busy && mult_theta == 8'd57) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("theta57_timeout");
        areset = 1'b1;
        exp_q.delete();
        @(negedge aclk);
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_s_ready", int'(s_ready), 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("after_rst_m_valid", int'(m_valid), 0);
        check("after_rst_busy", int'(busy), 0);
        check("after_rst_s_ready", int'(s_ready), 1);
        @(posedge aclk);
        #1;
        reset_track();
        send_pixel(20, 40, 1'b1, acc);
        wait_drain(400);
        check("restart_votes", vote_cnt, 180);
        check("restart_theta0_rho", got_rho[0], 1044);
        check("restart_last_cnt", last_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
